// File: rtl/line_store_pkg.sv
// Shared constants for the line store: state encoding, file depth, index width.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package line_store_pkg;

    localparam int LS_DEPTH = 64;
    localparam int LS_IDX_W = 6;

    localparam logic [1:0] ST_LOAD  = 2'b00;
    localparam logic [1:0] ST_SERVE = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    // The controller advances line_index before the datapath result is ready,
    // so a result belongs to the previous line; index 0 wraps to the last line.
    function automatic logic [LS_IDX_W-1:0] prev_line(input logic [LS_IDX_W-1:0] idx);
        return idx - LS_IDX_W'(1);
    endfunction

endpackage

// File: rtl/line_store_ram.sv
// Line file: DEPTH x DATA_W storage, one write port, one asynchronous read port.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; contents are never cleared by reset.
module line_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              i_wr_vld,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_dat
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Single write port; storage carries no reset so reset never wipes a file.
    always_ff @(posedge clk) begin
        if (i_wr_vld) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/line_store.sv
// Line store: fills an input file, serves lines to a datapath, collects results, drains an output file.
// Latency: line_data 1 cycle after line_index in SERVE; out_data combinational from drain_ptr.
// Backpressure: load_ready low once 64 lines are held; drain stalls on out_ready low. Macro LINE_STORE_CHECK_EN adds err.
module line_store
    import line_store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = LS_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                read_file,
    input  logic                write_reg,
    input  logic                write_file,
    input  logic                finish,
    input  logic [LS_IDX_W-1:0] line_index,
    output logic [DATA_W-1:0]   line_data,
    input  logic [DATA_W-1:0]   result_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
`ifdef LINE_STORE_CHECK_EN
    output logic                err,
`endif
    output logic                busy
);

    localparam logic [LS_IDX_W:0]   DEPTH_C  = (LS_IDX_W+1)'(DEPTH);
    localparam logic [LS_IDX_W-1:0] LAST_PTR = LS_IDX_W'(DEPTH - 1);

    logic [1:0]            r_state;
    logic [LS_IDX_W:0]     r_load_cnt;
    logic [LS_IDX_W-1:0]   r_drain_ptr;
    logic [DATA_W-1:0]     r_line_data;

    logic                  w_in_load;
    logic                  w_in_serve;
    logic                  w_in_drain;
    logic                  w_load_hs;
    logic                  w_out_hs;
    logic                  w_out_wr_vld;
    logic [DATA_W-1:0]     w_in_rd_dat;
    logic [DATA_W-1:0]     w_out_rd_dat;

    // write_reg only tells the datapath that line_data is meaningful; the
    // store refreshes line_data every SERVE cycle regardless.
    logic                  w_unused;
    assign w_unused = &{1'b0, write_reg};

    assign w_in_load    = (r_state == ST_LOAD);
    assign w_in_serve   = (r_state == ST_SERVE);
    assign w_in_drain   = (r_state == ST_DRAIN);

    assign load_ready   = w_in_load && (r_load_cnt < DEPTH_C);
    assign w_load_hs    = load_valid && load_ready;
    assign w_out_wr_vld = w_in_serve && write_file;

    assign out_valid    = w_in_drain;
    assign out_data     = w_out_rd_dat;
    assign out_last     = w_in_drain && (r_drain_ptr == LAST_PTR);
    assign w_out_hs     = out_valid && out_ready;
    assign busy         = w_in_serve || w_in_drain;
    assign line_data    = r_line_data;

    line_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(LS_IDX_W)) u_in_mem (
        .clk       (clk),
        .i_wr_vld  (w_load_hs),
        .i_wr_addr (r_load_cnt[LS_IDX_W-1:0]),
        .i_wr_dat  (load_data),
        .i_rd_addr (line_index),
        .o_rd_dat  (w_in_rd_dat)
    );

    line_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(LS_IDX_W)) u_out_mem (
        .clk       (clk),
        .i_wr_vld  (w_out_wr_vld),
        .i_wr_addr (prev_line(line_index)),
        .i_wr_dat  (result_data),
        .i_rd_addr (r_drain_ptr),
        .o_rd_dat  (w_out_rd_dat)
    );

    // Phase sequencing: fill, serve, drain; the fill count saturates at DEPTH.
    // A simultaneous write_file and finish is safe: the out_mem write lands on
    // the same edge that moves the state to DRAIN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_LOAD;
            r_load_cnt  <= '0;
            r_drain_ptr <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_load_hs) begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                    if (read_file) begin
                        r_state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (finish) begin
                        r_state     <= ST_DRAIN;
                        r_drain_ptr <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_hs) begin
                        if (out_last) begin
                            r_state     <= ST_LOAD;
                            r_load_cnt  <= '0;
                            r_drain_ptr <= '0;
                        end else begin
                            r_drain_ptr <= r_drain_ptr + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Registered input line toward the datapath, refreshed every SERVE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_line_data <= '0;
        end else if (w_in_serve) begin
            r_line_data <= w_in_rd_dat;
        end
    end

`ifdef LINE_STORE_CHECK_EN
    logic [6:0] r_wr_cnt;
    logic       r_err;
    logic [6:0] w_wr_cnt_nxt;

    // A write_file coinciding with finish still counts toward the total.
    assign w_wr_cnt_nxt = r_wr_cnt + {6'd0, write_file};
    assign err          = r_err;

    // Count result writes per pass; flag (sticky) a pass that wrote too few or too many.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_cnt <= '0;
            r_err    <= 1'b0;
        end else if (w_in_load && read_file) begin
            r_wr_cnt <= '0;
        end else if (w_in_serve) begin
            r_wr_cnt <= w_wr_cnt_nxt;
            if (finish && (w_wr_cnt_nxt != DEPTH_C)) begin
                r_err <= 1'b1;
            end
        end
    end
`endif

endmodule
